period_ramp: RTL and testbench
==============================

PERIOD_RAMP -- requirements
Module: period_ramp

Interface
REQ-001 Parameter CW, default 33, width of the half-period count.
REQ-002 Parameter SW, default 16, width of the step size.
REQ-003 Parameter IW, default 24, width of the update interval.
REQ-004 CLOCK input 1: sole clock; all state updates on its rising edge.
REQ-005 RESET_N input 1: reset, asynchronous and active-low.
REQ-006 start input 1: single-cycle request to begin a ramp; honoured only in IDLE.
REQ-007 abort input 1: level; forces return to IDLE.
REQ-008 start_count input CW: first half-period value; sampled on accepted start.
REQ-009 target_count input CW: final half-period value; sampled on accepted start.
REQ-010 step_size input SW: per-update change magnitude; sampled on accepted start.
REQ-011 step_interval input IW: CLOCK cycles between updates; sampled on accepted start.
REQ-012 set_count output CW: half-period count driven to the downstream variable clock divider.
REQ-013 busy output 1: high in RAMP and HOLD.
REQ-014 at_target output 1: high while set_count equals the latched target in HOLD.
REQ-015 done output 1: single-cycle pulse on the RAMP-to-HOLD transition.

Function
REQ-016 States: IDLE, RAMP, HOLD; encoding from the shared package.
REQ-017 IDLE: set_count = 0 (divider stopped), busy = 0, at_target = 0.
REQ-018 IDLE + start = 1: latch all four config inputs; next cycle set_count = max(start_count, 1), state RAMP, interval timer cleared.
REQ-019 start_count = 0 or target_count = 0: each treated as 1; set_count never nonzero-below-1 while busy.
REQ-020 RAMP: timer counts 0..step_interval-1; on the cycle it reaches step_interval-1 it wraps to 0 and set_count updates once.
REQ-021 step_interval = 0 treated as 1 (update every cycle).
REQ-022 Update toward target: if set_count > target, set_count - step; if less, set_count + step; arithmetic in CW+1 bits, result clamped to target, never overshooting or wrapping.
REQ-023 step_size = 0 treated as 1.
REQ-024 When set_count equals target (including on entry when start equals target): next cycle state HOLD, done = 1 for exactly one cycle.
REQ-025 HOLD: set_count held at target, at_target = 1, busy = 1; start ignored.
REQ-026 abort = 1 in RAMP or HOLD: next cycle state IDLE, set_count = 0, no done pulse; abort has priority over start and over a simultaneous update.
REQ-027 abort = 1 together with start in IDLE: start ignored.
REQ-028 Leaving HOLD only via abort or reset.
REQ-029 Config inputs changing while busy have no effect.
REQ-030 set_count changes at most once per CLOCK cycle and only at documented points, so the divider never sees an intermediate value.

Reset
REQ-031 RESET_N low asynchronously forces state IDLE, set_count = 0, busy = 0, at_target = 0, done = 0, timer = 0, latched config = 0.
REQ-032 Reset asserted mid-ramp discards the ramp; after release the block waits in IDLE for a new start.
REQ-033 Release of RESET_N takes effect on the first following rising CLOCK edge.

Structure
REQ-034 Shared package period_ramp_pkg holds the state typedef, default CW/SW/IW values, and the minimum-count constant (1).
REQ-035 One sub-module ramp_tick: IW-bit interval timer with clear input and single-cycle tick output; all other logic in period_ramp.
REQ-036 All outputs registered; no combinational path from inputs to outputs.

Verification
REQ-037 Decel ramp: start=1000, target=400, step=100, interval=4 -> set_count 1000,900,...,400 changing every 4 cycles; done once; at_target=1.
REQ-038 Clamp: start=100, target=250, step=60, interval=1 -> set_count 100,160,220,250; no value above 250.
REQ-039 Zero handling: start=0, target=5, step=0, interval=0 -> set_count 1,2,3,4,5 on consecutive cycles, then HOLD.
REQ-040 Abort: abort asserted mid-ramp at set_count=700 -> next cycle IDLE, set_count=0, no done; start ignored while abort high.
REQ-041 Async reset: RESET_N pulsed low between edges during HOLD -> outputs zero immediately, before next CLOCK edge.
REQ-042 Equal endpoints: start=target=300 -> set_count=300, done pulse next cycle, HOLD with at_target=1.

Source files
------------

// File: rtl/period_ramp_pkg.sv
// period_ramp_pkg
// Shared definitions for the period ramp controller: FSM state encoding,
// default parameter widths and the smallest half-period the divider accepts.
package period_ramp_pkg;

   localparam int CW_DEF = 33;   // half-period count width
   localparam int SW_DEF = 16;   // step size width
   localparam int IW_DEF = 24;   // update interval width

   // The divider cannot run with a zero half-period, so every count the
   // ramp drives while busy is at least this value.
   localparam int MIN_COUNT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } ramp_state_t;

endpackage

// File: rtl/period_ramp_tick.sv
// ramp_tick
// Interval timer for the ramp. Counts 0..interval-1 while enabled and
// raises tick on the cycle the count sits at interval-1, wrapping to 0 on
// the following edge. clear holds the count at 0.
//
// Ports
//   CLOCK     in   clock
//   RESET_N   in   asynchronous active-low reset
//   clear     in   force count to 0 (also suppresses tick)
//   enable    in   advance the count
//   interval  in   IW  cycles per tick, must already be >= 1
//   tick      out  single-cycle update strobe
module ramp_tick
   import period_ramp_pkg::*;
#(
   parameter int IW = IW_DEF
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic          clear,
   input  logic          enable,
   input  logic [IW-1:0] interval,
   output logic          tick
);

   logic [IW-1:0] count_q;
   logic          wrap;

   assign wrap = (count_q == (interval - IW'(1)));
   assign tick = enable && !clear && wrap;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= wrap ? '0 : count_q + IW'(1);
      end
   end

endmodule

// File: rtl/period_ramp.sv
// period_ramp
// Steps the half-period count of a downstream variable clock divider from
// a start value to a target value in fixed increments, one update every
// step_interval cycles, then holds at the target until aborted or reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | divider stopped (set_count = 0), waiting for start
// RAMP  | stepping set_count toward the latched target
// HOLD  | set_count parked at target, at_target high
//
// Ports
//   CLOCK          in   clock
//   RESET_N        in   asynchronous active-low reset
//   start          in   single-cycle ramp request, honoured in IDLE only
//   abort          in   level, returns to IDLE
//   start_count    in   CW  first half-period, sampled on accepted start
//   target_count   in   CW  final half-period, sampled on accepted start
//   step_size      in   SW  per-update change, sampled on accepted start
//   step_interval  in   IW  cycles between updates, sampled on accepted start
//   set_count      out  CW  half-period to the divider (registered)
//   busy           out  high in RAMP and HOLD (registered)
//   at_target      out  high in HOLD (registered)
//   done           out  one-cycle pulse on RAMP->HOLD (registered)
module period_ramp
   import period_ramp_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int SW = SW_DEF,
   parameter int IW = IW_DEF
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] start_count,
   input  logic [CW-1:0] target_count,
   input  logic [SW-1:0] step_size,
   input  logic [IW-1:0] step_interval,
   output logic [CW-1:0] set_count,
   output logic          busy,
   output logic          at_target,
   output logic          done
);

   localparam int XW = CW + 1;

   ramp_state_t   state_q, state_d;
   logic [CW-1:0] set_q, set_d;
   logic          busy_d, at_target_d, done_d;
   logic          latch_en;

   logic [CW-1:0] target_q;
   logic [SW-1:0] step_q;
   logic [IW-1:0] interval_q;

   logic          tick;
   logic          tick_clear;
   logic [XW-1:0] up_sum;
   logic [XW-1:0] dn_diff;
   logic [CW-1:0] stepped;

   // Timer only runs in RAMP; it is zero on every entry into RAMP.
   assign tick_clear = (state_q != ST_RAMP) || abort;

   ramp_tick #(.IW(IW)) u_tick (
      .CLOCK    (CLOCK),
      .RESET_N  (RESET_N),
      .clear    (tick_clear),
      .enable   (state_q == ST_RAMP),
      .interval (interval_q),
      .tick     (tick)
   );

   // One extra bit catches both the carry going up and the borrow going
   // down, so the clamp to target is exact and nothing wraps.
   always_comb begin
      up_sum  = {1'b0, set_q} + XW'(step_q);
      dn_diff = {1'b0, set_q} - XW'(step_q);
      stepped = target_q;
      if (set_q < target_q) begin
         if (up_sum <= {1'b0, target_q}) stepped = up_sum[CW-1:0];
      end else begin
         if (!dn_diff[CW] && (dn_diff[CW-1:0] >= target_q)) stepped = dn_diff[CW-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      done_d   = 1'b0;
      latch_en = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            set_d = '0;
            if (start && !abort) begin
               state_d  = ST_RAMP;
               latch_en = 1'b1;
               set_d    = (start_count == '0) ? CW'(MIN_COUNT) : start_count;
            end
         end
         ST_RAMP: begin
            if (abort) begin
               state_d = ST_IDLE;
               set_d   = '0;
            end else if (set_q == target_q) begin
               state_d = ST_HOLD;
               done_d  = 1'b1;
            end else if (tick) begin
               set_d = stepped;
            end
         end
         ST_HOLD: begin
            if (abort) begin
               state_d = ST_IDLE;
               set_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            set_d   = '0;
         end
      endcase
      busy_d      = (state_d != ST_IDLE);
      at_target_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         set_q     <= '0;
         busy      <= 1'b0;
         at_target <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_q     <= set_d;
         busy      <= busy_d;
         at_target <= at_target_d;
         done      <= done_d;
      end
   end

   // Zero target, step or interval would stall or undershoot the ramp, so
   // each is promoted to 1 as it is captured.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         target_q   <= '0;
         step_q     <= '0;
         interval_q <= '0;
      end else if (latch_en) begin
         target_q   <= (target_count == '0) ? CW'(MIN_COUNT) : target_count;
         step_q     <= (step_size == '0) ? SW'(1) : step_size;
         interval_q <= (step_interval == '0) ? IW'(1) : step_interval;
      end
   end

   assign set_count = set_q;

endmodule

// File: tb/tb_period_ramp.sv
module tb_period_ramp;

   localparam int CW = 33;
   localparam int SW = 16;
   localparam int IW = 24;

   logic          CLOCK;
   logic          RESET_N;
   logic          start;
   logic          abort;
   logic [CW-1:0] start_count;
   logic [CW-1:0] target_count;
   logic [SW-1:0] step_size;
   logic [IW-1:0] step_interval;
   logic [CW-1:0] set_count;
   logic          busy;
   logic          at_target;
   logic          done;

   int total = 0;
   int bad   = 0;

   period_ramp #(.CW(CW), .SW(SW), .IW(IW)) dut (
      .CLOCK         (CLOCK),
      .RESET_N       (RESET_N),
      .start         (start),
      .abort         (abort),
      .start_count   (start_count),
      .target_count  (target_count),
      .step_size     (step_size),
      .step_interval (step_interval),
      .set_count     (set_count),
      .busy          (busy),
      .at_target     (at_target),
      .done          (done)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input longint e_set, input bit e_busy,
                            input bit e_done, input bit e_at);
      check({tag, " set_count"}, {31'b0, set_count}, e_set);
      check({tag, " busy"}, {63'b0, busy}, {63'b0, e_busy});
      check({tag, " done"}, {63'b0, done}, {63'b0, e_done});
      check({tag, " at_target"}, {63'b0, at_target}, {63'b0, e_at});
   endtask

   task automatic scramble_cfg();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      start_count = r[CW-1:0];
      r = {$urandom(), $urandom()};
      target_count = r[CW-1:0];
      r = {$urandom(), $urandom()};
      step_size = r[SW-1:0];
      step_interval = r[IW-1:0];
   endtask

   // Reference: the list of distinct set_count values the ramp visits, each
   // held for one interval, then one more cycle at target before HOLD.
   task automatic run_ramp(input string tag, input longint s, input longint t,
                           input longint st, input longint iv, input int extra_hold,
                           input int stop_at, input bit by_reset);
      longint q[$];
      longint s1, t1, st1, v;
      int     n, m, last;
      longint e_set;
      bit     e_done, e_at;
      s1  = (s == 0) ? 1 : s;
      t1  = (t == 0) ? 1 : t;
      st1 = (st == 0) ? 1 : st;
      n   = (iv == 0) ? 1 : int'(iv);
      v   = s1;
      q.push_back(v);
      while (v != t1) begin
         if (v < t1) v = (v + st1 > t1) ? t1 : v + st1;
         else        v = (v - st1 < t1) ? t1 : v - st1;
         q.push_back(v);
      end
      m    = q.size() - 1;
      last = m * n + 1 + extra_hold;

      start_count   = s[CW-1:0];
      target_count  = t[CW-1:0];
      step_size     = st[SW-1:0];
      step_interval = iv[IW-1:0];
      start = 1'b1;
      @(negedge CLOCK);
      start = 1'b0;
      scramble_cfg();

      for (int k = 0; k <= last; k++) begin
         if (k <= m * n) begin
            e_set = q[k / n]; e_done = 1'b0; e_at = 1'b0;
         end else begin
            e_set = t1; e_done = (k == m * n + 1); e_at = 1'b1;
         end
         check_all($sformatf("%s k=%0d", tag, k), e_set, 1'b1, e_done, e_at);
         if (k == stop_at) begin
            start = 1'b0;
            if (by_reset) begin
               #2 RESET_N = 1'b0;
               #1 check_all({tag, " async"}, 0, 1'b0, 1'b0, 1'b0);
               @(negedge CLOCK);
               check_all({tag, " in_reset"}, 0, 1'b0, 1'b0, 1'b0);
               RESET_N = 1'b1;
               for (int j = 0; j < 3; j++) begin
                  @(negedge CLOCK);
                  check_all($sformatf("%s post_reset%0d", tag, j), 0, 1'b0, 1'b0, 1'b0);
               end
            end else begin
               abort = 1'b1;
               start = 1'b1;
               @(negedge CLOCK);
               check_all({tag, " abort"}, 0, 1'b0, 1'b0, 1'b0);
               @(negedge CLOCK);
               check_all({tag, " abort_start"}, 0, 1'b0, 1'b0, 1'b0);
               abort = 1'b0;
               start = 1'b0;
               @(negedge CLOCK);
               check_all({tag, " idle"}, 0, 1'b0, 1'b0, 1'b0);
            end
            return;
         end
         if (k > m * n + 1) begin
            start = 1'b1;
            scramble_cfg();
         end
         if (k < last) @(negedge CLOCK);
      end
      start = 1'b0;
   endtask

   task automatic do_abort(input string tag);
      abort = 1'b1;
      start = 1'b1;
      @(negedge CLOCK);
      check_all({tag, " abort"}, 0, 1'b0, 1'b0, 1'b0);
      @(negedge CLOCK);
      check_all({tag, " abort_start"}, 0, 1'b0, 1'b0, 1'b0);
      abort = 1'b0;
      start = 1'b0;
      @(negedge CLOCK);
   endtask

   initial begin
      longint rs, rt, rst, riv;
      RESET_N = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      start_count = '0; target_count = '0; step_size = '0; step_interval = '0;
      repeat (2) @(negedge CLOCK);
      check_all("reset", 0, 1'b0, 1'b0, 1'b0);
      RESET_N = 1'b1;
      @(negedge CLOCK);
      check_all("idle", 0, 1'b0, 1'b0, 1'b0);

      run_ramp("decel", 1000, 400, 100, 4, 2, -1, 1'b0);
      do_abort("decel");
      run_ramp("clamp", 100, 250, 60, 1, 2, -1, 1'b0);
      do_abort("clamp");
      run_ramp("zero", 0, 5, 0, 0, 2, -1, 1'b0);
      do_abort("zero");
      run_ramp("abort_mid", 1000, 400, 100, 4, 0, 12, 1'b0);
      run_ramp("equal_hold_rst", 300, 300, 7, 3, 2, 3, 1'b1);
      run_ramp("mid_rst", 50, 500, 10, 2, 0, 7, 1'b1);
      run_ramp("top_clamp", 64'h1_FFFF_FFF6, 64'h1_FFFF_FFFF, 50000, 2, 2, -1, 1'b0);
      do_abort("top_clamp");
      run_ramp("zero_target", 20, 0, 100, 3, 2, -1, 1'b0);
      do_abort("zero_target");
      run_ramp("up_then_down", 10, 37, 9, 2, 1, -1, 1'b0);
      do_abort("up_then_down");

      for (int i = 0; i < 10; i++) begin
         rs  = longint'($urandom_range(0, 400));
         rt  = longint'($urandom_range(0, 400));
         rst = longint'($urandom_range(0, 80));
         riv = longint'($urandom_range(0, 4));
         run_ramp($sformatf("rnd%0d", i), rs, rt, rst, riv, 1, -1, 1'b0);
         do_abort($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
